spmv_mem_sched: RTL and testbench

- Shares the single SpMV memory port (mem_req_* / mem_resp_*, 6-bit transid, up to 64 outstanding) between NUM_REQ internal fetch engines (row-ptr, col-idx, value, x-vector).
- Round-robin arbitration; allocates a free transid per request; records the owner per transid; steers each out-of-order response back to its owner; frees the transid on response.

---
 rtl/spmv_pkg.sv | 22 ++
 rtl/spmv_tid_pool.sv | 68 ++++++
 rtl/spmv_mem_sched.sv | 134 +++++++++++++
 tb/tb_spmv_mem_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared types and helpers for the SpMV memory scheduler and its ID pool.
package spmv_pkg;

    localparam int SPMV_TID_W     = 6;
    localparam int SPMV_MAX_TID   = 64;
    localparam int SPMV_REQ_IDX_W = 3;

    typedef logic [SPMV_TID_W-1:0]     spmv_tid_t;
    typedef logic [SPMV_TID_W:0]       spmv_cnt_t;
    typedef logic [SPMV_REQ_IDX_W-1:0] spmv_req_idx_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic spmv_req_idx_t onehot_to_idx(input logic [7:0] onehot);
        spmv_req_idx_t idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | spmv_req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spmv_tid_pool.sv
// Transaction-ID pool: in-use bitmap, lowest-free allocator, free port and count.
// Allocation looks at the bitmap before this cycle's free, so an ID being
// freed only becomes allocatable on the following cycle.
module spmv_tid_pool
    import spmv_pkg::*;
#(
    parameter int NUM_IDS = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      alloc,
    output spmv_tid_t alloc_id,
    output logic      avail,
    input  logic      free,
    input  spmv_tid_t free_id,
    output logic      free_hit,
    output spmv_cnt_t count
);

    logic [NUM_IDS-1:0] inuse;
    logic [NUM_IDS-1:0] inuse_d;
    logic               alloc_ok;
    logic               free_ok;

    // Lowest free ID; descending scan so the smallest index wins.
    always_comb begin
        alloc_id = '0;
        avail    = 1'b0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (!inuse[i]) begin
                alloc_id = spmv_tid_t'(i);
                avail    = 1'b1;
            end
        end
    end

    // Is the ID being returned actually in use (IDs beyond NUM_IDS never are).
    always_comb begin
        free_hit = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (free_id == spmv_tid_t'(i)) free_hit = inuse[i];
        end
    end

    assign alloc_ok = alloc && avail;
    assign free_ok  = free && free_hit;

    // Next bitmap: set the allocated ID, clear the freed one (never the same ID).
    always_comb begin
        inuse_d = inuse;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (alloc_ok && alloc_id == spmv_tid_t'(i)) inuse_d[i] = 1'b1;
            if (free_ok && free_id == spmv_tid_t'(i))   inuse_d[i] = 1'b0;
        end
    end

    // Bitmap and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inuse <= '0;
            count <= '0;
        end else begin
            inuse <= inuse_d;
            count <= count + spmv_cnt_t'(alloc_ok) - spmv_cnt_t'(free_ok);
        end
    end

endmodule

// File: rtl/spmv_mem_sched.sv
// Shares one SpMV memory port between NUM_REQ fetch engines: round-robin
// arbitration, transid allocation, owner tracking and response steering.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_rdy is computed from req_val (requesters must not wait for
// req_rdy before raising req_val); mem_req_val/addr/transid hold steady while
// mem_req_rdy is low; mem_resp_val has no backpressure.
module spmv_mem_sched
    import spmv_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 64,
    parameter int PADDR_W = 48,
    parameter int DATA_W  = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_val,
    input  logic [NUM_REQ*PADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic [NUM_REQ-1:0]         resp_val,
    output logic [DATA_W-1:0]          resp_data,
    input  logic                       mem_req_rdy,
    output logic                       mem_req_val,
    output spmv_tid_t                  mem_req_transid,
    output logic [PADDR_W-1:0]         mem_req_addr,
    input  logic                       mem_resp_val,
    input  spmv_tid_t                  mem_resp_transid,
    input  logic [DATA_W-1:0]          mem_resp_data,
    output spmv_cnt_t                  outstanding,
    output logic                       idle,
    output logic                       err_spurious
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    spmv_req_idx_t      winner;
    logic [PADDR_W-1:0] win_addr;
    logic               can_issue;
    logic               accept;
    spmv_tid_t          alloc_id;
    logic               id_avail;
    logic               resp_hit;
    logic               resp_ok;
    spmv_req_idx_t      owner [SPMV_MAX_TID];

    spmv_tid_pool #(.NUM_IDS(MAX_OUT)) u_pool (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc    (accept),
        .alloc_id (alloc_id),
        .avail    (id_avail),
        .free     (mem_resp_val),
        .free_id  (mem_resp_transid),
        .free_hit (resp_hit),
        .count    (outstanding)
    );

    // Round-robin search: first active requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_val[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // Address of the winning requester.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_addr = req_addr[i*PADDR_W +: PADDR_W];
        end
    end

    assign winner    = onehot_to_idx(8'(grant));
    assign can_issue = (!mem_req_val || mem_req_rdy) && id_avail;
    assign req_rdy   = can_issue ? grant : '0;
    assign accept    = can_issue && found;
    assign resp_ok   = mem_resp_val && resp_hit;
    assign idle      = (outstanding == '0) && !mem_req_val;

    // Memory request output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_val     <= 1'b0;
            mem_req_transid <= '0;
            mem_req_addr    <= '0;
            rr_ptr          <= '0;
        end else if (accept) begin
            mem_req_val     <= 1'b1;
            mem_req_transid <= alloc_id;
            mem_req_addr    <= win_addr;
            if (winner == spmv_req_idx_t'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                       rr_ptr <= PTR_W'(winner + 3'd1);
        end else if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
        end
    end

    // Owner table: which requester issued each live transid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < SPMV_MAX_TID; t++) owner[t] <= '0;
        end else if (accept) begin
            owner[alloc_id] <= winner;
        end
    end

    // Response steering and sticky spurious-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val     <= '0;
            resp_data    <= '0;
            err_spurious <= 1'b0;
        end else begin
            resp_val <= '0;
            if (resp_ok) begin
                resp_val  <= NUM_REQ'(1) << owner[mem_resp_transid];
                resp_data <= mem_resp_data;
            end
            if (mem_resp_val && !resp_hit) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spmv_mem_sched.sv
// Self-checking bench for spmv_mem_sched: directed scenarios plus a
// randomized run, all compared with a transaction-level model.
module tb_spmv_mem_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_val;
    logic [191:0] req_addr;
    logic [3:0]   req_rdy;
    logic [3:0]   resp_val;
    logic [511:0] resp_data;
    logic         mem_req_rdy;
    logic         mem_req_val;
    logic [5:0]   mem_req_transid;
    logic [47:0]  mem_req_addr;
    logic         mem_resp_val;
    logic [5:0]   mem_resp_transid;
    logic [511:0] mem_resp_data;
    logic [6:0]   outstanding;
    logic         idle;
    logic         err_spurious;

    logic [47:0]  addr_a [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (transaction level)
    bit           m_inuse [64];
    int           m_owner [64];
    int           m_rr;
    int           m_out;
    bit           m_mval;
    int           m_mtid;
    logic [47:0]  m_maddr;
    logic [3:0]   m_resp_val;
    logic [511:0] m_resp_data;
    bit           m_err;
    logic [47:0]  exp_q [$];

    spmv_mem_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_val          (req_val),
        .req_addr         (req_addr),
        .req_rdy          (req_rdy),
        .resp_val         (resp_val),
        .resp_data        (resp_data),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_val      (mem_req_val),
        .mem_req_transid  (mem_req_transid),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .outstanding      (outstanding),
        .idle             (idle),
        .err_spurious     (err_spurious)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-requester addresses
    always_comb begin
        req_addr = '0;
        for (int i = 0; i < 4; i++) req_addr[i*48 +: 48] = addr_a[i];
    end

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [47:0] rand_addr();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Expected grant: first requesting index at or after the RR pointer,
    // nothing when the port is busy or every ID is in use.
    function automatic logic [3:0] model_rdy();
        if (m_mval && !mem_req_rdy) return 4'b0000;
        if (m_out >= 64) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_rr + k) % 4;
            if (req_val[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 64; j++) begin
            m_inuse[j] = 1'b0;
            m_owner[j] = 0;
        end
        m_rr        = 0;
        m_out       = 0;
        m_mval      = 1'b0;
        m_mtid      = 0;
        m_maddr     = '0;
        m_resp_val  = '0;
        m_resp_data = '0;
        m_err       = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [3:0] g;
        int w, id, tid;
        bit ok;
        g   = model_rdy();
        tid = int'(mem_resp_transid);
        ok  = mem_resp_val && m_inuse[tid];
        w   = -1;
        for (int i = 0; i < 4; i++) if (g[i]) w = i;
        id = -1;
        for (int j = 63; j >= 0; j--) if (!m_inuse[j]) id = j;
        if (ok) begin
            m_resp_val  = 4'(1 << m_owner[tid]);
            m_resp_data = mem_resp_data;
            m_inuse[tid] = 1'b0;
            m_out--;
        end else begin
            m_resp_val = 4'b0000;
        end
        if (mem_resp_val && !ok) m_err = 1'b1;
        if (w >= 0) begin
            m_inuse[id] = 1'b1;
            m_owner[id] = w;
            m_rr        = (w + 1) % 4;
            m_out++;
            m_mval  = 1'b1;
            m_mtid  = id;
            m_maddr = addr_a[w];
            exp_q.push_back(addr_a[w]);
        end else if (mem_req_rdy) begin
            m_mval = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_val      = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data    = '0;
        for (int i = 0; i < 4; i++) addr_a[i] = '0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_val: got %0h exp 0", mem_req_val); end
        n_tests++; if (mem_req_transid !== 6'd0) begin n_fail++; $display("FAIL reset_transid: got %0h exp 0", mem_req_transid); end
        n_tests++; if (mem_req_addr !== 48'd0) begin n_fail++; $display("FAIL reset_addr: got %0h exp 0", mem_req_addr); end
        n_tests++; if (resp_val !== 4'd0) begin n_fail++; $display("FAIL reset_resp_val: got %0h exp 0", resp_val); end
        n_tests++; if (resp_data !== 512'd0) begin n_fail++; $display("FAIL reset_resp_data: got %0h exp 0", resp_data); end
        n_tests++; if (outstanding !== 7'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0h exp 1", idle); end
        n_tests++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h exp 0", err_spurious); end
    endtask

    task automatic test_single();
        logic [511:0] d;
        do_reset();
        mem_req_rdy = 1'b1;
        addr_a[2]   = 48'h1000;
        req_val     = 4'b0100;
        #1;
        n_tests++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_req_rdy: got %b exp 0100", req_rdy); end
        tick();
        req_val = 4'b0000;
        n_tests++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL single_mem_req_val: got %0h exp 1", mem_req_val); end
        n_tests++; if (mem_req_transid !== 6'd0) begin n_fail++; $display("FAIL single_transid: got %0d exp 0", mem_req_transid); end
        n_tests++; if (mem_req_addr !== 48'h1000) begin n_fail++; $display("FAIL single_addr: got %0h exp 1000", mem_req_addr); end
        n_tests++; if (outstanding !== 7'd1 || idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got out=%0d idle=%0h exp out=1 idle=0", outstanding, idle); end
        tick();
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL single_mem_req_drop: got %0h exp 0", mem_req_val); end
        d = rand_data();
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd0;
        mem_resp_data    = d;
        tick();
        mem_resp_val = 1'b0;
        n_tests++; if (resp_val !== 4'b0100) begin n_fail++; $display("FAIL single_resp_val: got %b exp 0100", resp_val); end
        n_tests++; if (resp_data !== d) begin n_fail++; $display("FAIL single_resp_data: got %0h exp %0h", resp_data, d); end
        n_tests++; if (outstanding !== 7'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got out=%0d idle=%0h exp out=0 idle=1", outstanding, idle); end
        tick();
        n_tests++; if (resp_val !== 4'b0000 || resp_data !== d) begin n_fail++; $display("FAIL single_resp_hold: got val=%b exp 0000 with data held", resp_val); end
    endtask

    task automatic test_round_robin();
        do_reset();
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) addr_a[i] = rand_addr();
        req_val = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_tests++; if (req_rdy !== 4'(1 << (n % 4))) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", n, req_rdy, 4'(1 << (n % 4))); end
            tick();
            n_tests++; if (mem_req_transid !== 6'(n) || mem_req_addr !== addr_a[n % 4]) begin n_fail++; $display("FAIL rr_issue%0d: got tid=%0d addr=%0h exp tid=%0d addr=%0h", n, mem_req_transid, mem_req_addr, n, addr_a[n % 4]); end
        end
        req_val = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        logic [47:0] a;
        do_reset();
        a = rand_addr();
        addr_a[1]   = a;
        mem_req_rdy = 1'b0;
        req_val     = 4'b0010;
        #1;
        n_tests++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant: got %b exp 0010", req_rdy); end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy_low%0d: got %b exp 0000", c, req_rdy); end
            n_tests++; if (mem_req_val !== 1'b1 || mem_req_addr !== a || mem_req_transid !== 6'd0) begin n_fail++; $display("FAIL bp_hold%0d: got val=%0h addr=%0h tid=%0d exp val=1 addr=%0h tid=0", c, mem_req_val, mem_req_addr, mem_req_transid, a); end
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        n_tests++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL bp_b2b_grant: got %b exp 0010", req_rdy); end
        tick();
        req_val = 4'b0000;
        n_tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd1) begin n_fail++; $display("FAIL bp_b2b_issue: got val=%0h tid=%0d exp val=1 tid=1", mem_req_val, mem_req_transid); end
        tick();
        n_tests++; if (mem_req_val !== 1'b0 || outstanding !== 7'd2) begin n_fail++; $display("FAIL bp_drain: got val=%0h out=%0d exp val=0 out=2", mem_req_val, outstanding); end
    endtask

    task automatic test_out_of_order();
        int owners [3] = '{0, 1, 3};
        int order  [3] = '{2, 0, 1};
        logic [3:0] exp_v [3] = '{4'b1000, 4'b0001, 4'b0010};
        logic [511:0] d;
        do_reset();
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_val = 4'(1 << owners[i]);
            tick();
        end
        req_val = 4'b0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            d = rand_data();
            mem_resp_val     = 1'b1;
            mem_resp_transid = 6'(order[i]);
            mem_resp_data    = d;
            tick();
            n_tests++; if (resp_val !== exp_v[i] || resp_data !== d) begin n_fail++; $display("FAIL ooo_resp%0d: got val=%b exp %b (data match=%0d)", i, resp_val, exp_v[i], resp_data === d); end
        end
        mem_resp_val = 1'b0;
        tick();
        n_tests++; if (outstanding !== 7'd0 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL ooo_drain: got out=%0d err=%0h exp out=0 err=0", outstanding, err_spurious); end
    endtask

    task automatic test_exhaustion();
        do_reset();
        mem_req_rdy = 1'b1;
        req_val     = 4'b0001;
        repeat (64) tick();
        #1;
        n_tests++; if (outstanding !== 7'd64) begin n_fail++; $display("FAIL exh_full: got %0d exp 64", outstanding); end
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL exh_rdy_low: got %b exp 0000", req_rdy); end
        n_tests++; if (mem_req_transid !== 6'd63) begin n_fail++; $display("FAIL exh_last_tid: got %0d exp 63", mem_req_transid); end
        tick();
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL exh_stall: got %0h exp 0", mem_req_val); end
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd2;
        mem_resp_data    = rand_data();
        #1;
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL exh_no_same_cycle: got %b exp 0000", req_rdy); end
        tick();
        mem_resp_val = 1'b0;
        n_tests++; if (outstanding !== 7'd63 || resp_val !== 4'b0001) begin n_fail++; $display("FAIL exh_freed: got out=%0d resp=%b exp out=63 resp=0001", outstanding, resp_val); end
        #1;
        n_tests++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL exh_resume_rdy: got %b exp 0001", req_rdy); end
        tick();
        n_tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd2 || outstanding !== 7'd64) begin n_fail++; $display("FAIL exh_reissue: got val=%0h tid=%0d out=%0d exp val=1 tid=2 out=64", mem_req_val, mem_req_transid, outstanding); end
        req_val = 4'b0000;
        tick();
    endtask

    task automatic test_spurious_reset();
        do_reset();
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd9;
        mem_resp_data    = rand_data();
        tick();
        mem_resp_val = 1'b0;
        n_tests++; if (resp_val !== 4'b0000 || err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_flag: got resp=%b err=%0h exp resp=0000 err=1", resp_val, err_spurious); end
        n_tests++; if (resp_data !== 512'd0 || outstanding !== 7'd0) begin n_fail++; $display("FAIL spur_nochange: got out=%0d exp 0 with data unchanged", outstanding); end
        tick();
        n_tests++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %0h exp 1", err_spurious); end
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) addr_a[i] = rand_addr();
        req_val = 4'b0111;
        repeat (3) tick();
        req_val = 4'b0000;
        tick();
        n_tests++; if (outstanding !== 7'd3) begin n_fail++; $display("FAIL spur_three_out: got %0d exp 3", outstanding); end
        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (mem_req_val !== 1'b0 || mem_req_transid !== 6'd0 || mem_req_addr !== 48'd0) begin n_fail++; $display("FAIL async_req_clear: got val=%0h tid=%0d addr=%0h exp 0", mem_req_val, mem_req_transid, mem_req_addr); end
        n_tests++; if (resp_val !== 4'd0 || resp_data !== 512'd0) begin n_fail++; $display("FAIL async_resp_clear: got val=%b exp 0000 and zero data", resp_val); end
        n_tests++; if (outstanding !== 7'd0 || idle !== 1'b1 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL async_status: got out=%0d idle=%0h err=%0h exp 0 1 0", outstanding, idle, err_spurious); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_val = 4'b1000;
        tick();
        req_val = 4'b0000;
        n_tests++; if (mem_req_transid !== 6'd0 || mem_req_val !== 1'b1) begin n_fail++; $display("FAIL post_reset_tid: got val=%0h tid=%0d exp val=1 tid=0", mem_req_val, mem_req_transid); end
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd1;
        tick();
        mem_resp_val = 1'b0;
        n_tests++; if (err_spurious !== 1'b1 || resp_val !== 4'b0000) begin n_fail++; $display("FAIL post_reset_stale: got err=%0h resp=%b exp err=1 resp=0000", err_spurious, resp_val); end
    endtask

    task automatic test_random();
        int live [$];
        logic [47:0] a;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_val     = 4'($urandom_range(0, 15));
            mem_req_rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) addr_a[i] = rand_addr();
            live.delete();
            for (int j = 0; j < 64; j++) if (m_inuse[j]) live.push_back(j);
            mem_resp_val  = 1'b0;
            mem_resp_data = rand_data();
            if (live.size() > 0 && $urandom_range(0, 9) < 4) begin
                mem_resp_val     = 1'b1;
                mem_resp_transid = 6'(live[$urandom_range(0, live.size() - 1)]);
            end else if ($urandom_range(0, 199) == 0) begin
                mem_resp_val     = 1'b1;
                mem_resp_transid = 6'($urandom_range(0, 63));
            end
            #1;
            n_tests++; if (req_rdy !== model_rdy()) begin n_fail++; $display("FAIL rnd_req_rdy@%0d: got %b exp %b", cyc, req_rdy, model_rdy()); end
            if (mem_req_val && mem_req_rdy) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected_issue@%0d: got addr=%0h exp no request", cyc, mem_req_addr);
                end else begin
                    a = exp_q.pop_front();
                    if (mem_req_addr !== a) begin n_fail++; $display("FAIL rnd_issue_addr@%0d: got %0h exp %0h", cyc, mem_req_addr, a); end
                end
            end
            tick();
            n_tests++; if (mem_req_val !== m_mval || mem_req_transid !== 6'(m_mtid) || mem_req_addr !== m_maddr) begin n_fail++; $display("FAIL rnd_mem_req@%0d: got val=%0h tid=%0d addr=%0h exp val=%0h tid=%0d addr=%0h", cyc, mem_req_val, mem_req_transid, mem_req_addr, m_mval, m_mtid, m_maddr); end
            n_tests++; if (resp_val !== m_resp_val || resp_data !== m_resp_data) begin n_fail++; $display("FAIL rnd_resp@%0d: got val=%b exp %b (data match=%0d)", cyc, resp_val, m_resp_val, resp_data === m_resp_data); end
            n_tests++; if (outstanding !== 7'(m_out) || idle !== (m_out == 0 && !m_mval) || err_spurious !== m_err) begin n_fail++; $display("FAIL rnd_status@%0d: got out=%0d idle=%0h err=%0h exp out=%0d idle=%0h err=%0h", cyc, outstanding, idle, err_spurious, m_out, (m_out == 0 && !m_mval), m_err); end
        end
        req_val      = 4'b0000;
        mem_resp_val = 1'b0;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        req_val      = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data    = '0;
        for (int i = 0; i < 4; i++) addr_a[i] = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_out_of_order();
        test_exhaustion();
        test_spurious_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
